// File: rtl/usr_burst_if.sv
// Bus bundle for usr_burst: operation control, serial data and status.
// With USR_PARITY_EN defined the bundle also carries the parity output.
interface usr_burst_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
);
   logic [2:0]       ctrl;
   logic [WIDTH-1:0] d;
   logic             sin_l;
   logic             sin_r;
   logic             start;
   logic [CNT_W-1:0] burst_len;
   logic [WIDTH-1:0] q;
   logic             sout_l;
   logic             sout_r;
   logic             busy;
   logic             done;
`ifdef USR_PARITY_EN
   logic             parity;
`endif

   modport master (
      output ctrl, d, sin_l, sin_r, start, burst_len,
`ifdef USR_PARITY_EN
      input  parity,
`endif
      input  q, sout_l, sout_r, busy, done
   );

   modport slave (
      input  ctrl, d, sin_l, sin_r, start, burst_len,
`ifdef USR_PARITY_EN
      output parity,
`endif
      output q, sout_l, sout_r, busy, done
   );
endinterface

// File: rtl/usr_burst.sv
// Universal shift register with a burst sequencer that repeats one
// shift/rotate op burst_len times from a single start request.
// Optional macro USR_PARITY_EN adds a registered parity output (== ^q).
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | ctrl applied every edge; may accept a burst start
// BURST | latched op repeated each edge until rem reaches 1
module usr_burst #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input logic       clk,
   input logic       rst,
   usr_burst_if.slave bus
);

   localparam logic [2:0] OP_HOLD = 3'b000;
   localparam logic [2:0] OP_SHR  = 3'b001;
   localparam logic [2:0] OP_SHL  = 3'b010;
   localparam logic [2:0] OP_LOAD = 3'b011;
   localparam logic [2:0] OP_ROR  = 3'b100;
   localparam logic [2:0] OP_ROL  = 3'b101;
   localparam logic [2:0] OP_ASR  = 3'b110;
   localparam logic [2:0] OP_CLR  = 3'b111;

   typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

   state_t           state, state_nx;
   logic [WIDTH-1:0] q_r, q_nx;
   logic             busy_r, busy_nx;
   logic             done_r, done_nx;
   logic [CNT_W-1:0] rem, rem_nx;
   logic [2:0]       op_lat, op_nx;

   function automatic logic is_shift(input logic [2:0] op);
      return (op == OP_SHR) || (op == OP_SHL) || (op == OP_ROR) ||
             (op == OP_ROL) || (op == OP_ASR);
   endfunction

   function automatic logic [WIDTH-1:0] apply_op(
      input logic [2:0]       op,
      input logic [WIDTH-1:0] cur,
      input logic [WIDTH-1:0] din,
      input logic             sl,
      input logic             sr
   );
      logic [WIDTH-1:0] res;
      res = cur;
      case (op)
         OP_HOLD: res = cur;
         OP_SHR:  res = {sr, cur[WIDTH-1:1]};
         OP_SHL:  res = {cur[WIDTH-2:0], sl};
         OP_LOAD: res = din;
         OP_ROR:  res = {cur[0], cur[WIDTH-1:1]};
         OP_ROL:  res = {cur[WIDTH-2:0], cur[WIDTH-1]};
         OP_ASR:  res = {cur[WIDTH-1], cur[WIDTH-1:1]};
         OP_CLR:  res = '0;
         default: res = cur;
      endcase
      return res;
   endfunction

   // Next-state, next-q and status decode.
   always_comb begin
      state_nx = state;
      q_nx     = q_r;
      busy_nx  = 1'b0;
      done_nx  = 1'b0;
      rem_nx   = rem;
      op_nx    = op_lat;
      case (state)
         IDLE: begin
            q_nx = apply_op(bus.ctrl, q_r, bus.d, bus.sin_l, bus.sin_r);
            if (bus.start && is_shift(bus.ctrl) && (bus.burst_len != '0)) begin
               op_nx = bus.ctrl;
               if (bus.burst_len == CNT_W'(1)) begin
                  done_nx = 1'b1;
               end else begin
                  busy_nx  = 1'b1;
                  rem_nx   = bus.burst_len - 1'b1;
                  state_nx = BURST;
               end
            end
         end
         BURST: begin
            // d is irrelevant here: the latched op is always shift-class
            q_nx   = apply_op(op_lat, q_r, bus.d, bus.sin_l, bus.sin_r);
            rem_nx = rem - 1'b1;
            if (rem == CNT_W'(1)) begin
               done_nx  = 1'b1;
               state_nx = IDLE;
            end else begin
               busy_nx = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         q_r    <= '0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
         rem    <= '0;
         op_lat <= OP_HOLD;
      end else begin
         state  <= state_nx;
         q_r    <= q_nx;
         busy_r <= busy_nx;
         done_r <= done_nx;
         rem    <= rem_nx;
         op_lat <= op_nx;
      end
   end

`ifdef USR_PARITY_EN
   logic parity_r;

   // Parity registered from the next q so it always matches ^q.
   always_ff @(posedge clk) begin
      if (rst) parity_r <= 1'b0;
      else     parity_r <= ^q_nx;
   end

   assign bus.parity = parity_r;
`endif

   assign bus.q      = q_r;
   assign bus.sout_l = q_r[WIDTH-1];
   assign bus.sout_r = q_r[0];
   assign bus.busy   = busy_r;
   assign bus.done   = done_r;

endmodule
